// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: serial-in parallel-out frame controller.
// Detects frame start, shifts W bits MSB-first, and hands each completed word
// to a valid/ready consumer through a single-entry holding register.
// Optional feature: define SIPO_FRAME_PARITY_CHECK_EN to expect one trailing
// even-parity bit per frame and report parity_err alongside pdata.

module sipo_frame_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         frame_start,
    input  logic         out_ready,
    input  logic         ovr_clr,
    output logic [W-1:0] pdata,
    output logic         pdata_valid,
    output logic         busy,
    output logic         overrun,
    output logic         parity_err
);

    localparam int unsigned   CW       = $clog2(W + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

`ifdef SIPO_FRAME_PARITY_CHECK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    state_t        state;
    logic [W-1:0]  shift_q;
    logic [CW-1:0] cnt;

    logic [W-1:0]  shift_nxt;
    logic [W-1:0]  word;
    logic          last_bit;
    logic          complete;
    logic          hold_free;
`ifdef SIPO_FRAME_PARITY_CHECK_EN
    logic          word_perr;
`endif

    // Next shift value, last-data-bit detect and frame completion strobe
    always_comb begin
        shift_nxt = {shift_q[W-2:0], sin};
        last_bit  = (state == SHIFT) && (cnt == LAST_CNT);
`ifdef SIPO_FRAME_PARITY_CHECK_EN
        // Word is already fully shifted; the current bit is the parity bit.
        // A frame_start on the parity bit is a resync, not a completion.
        complete  = sin_valid && (state == PARITY) && !frame_start;
        word      = shift_q;
        word_perr = ^{shift_q, sin};
`else
        complete  = sin_valid && last_bit;
        word      = shift_nxt;
`endif
        hold_free = !pdata_valid || out_ready;
    end

    // Frame FSM: start detect, bit counting, resync and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt     <= '0;
        end else if (sin_valid) begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        shift_q <= shift_nxt;
                        cnt     <= CW'(1);
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shift_q <= shift_nxt;
                    if (last_bit) begin
                        // Final data bit wins over a coincident frame_start
                        cnt <= '0;
`ifdef SIPO_FRAME_PARITY_CHECK_EN
                        state <= PARITY;
`else
                        state <= IDLE;
`endif
                    end else if (frame_start) begin
                        // Resync: drop partial frame, this bit is bit 0
                        cnt <= CW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef SIPO_FRAME_PARITY_CHECK_EN
                PARITY: begin
                    if (frame_start) begin
                        shift_q <= shift_nxt;
                        cnt     <= CW'(1);
                        state   <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Single-entry holding register with valid/ready handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            pdata       <= '0;
            pdata_valid <= 1'b0;
        end else if (complete && hold_free) begin
            pdata       <= word;
            pdata_valid <= 1'b1;
        end else if (pdata_valid && out_ready) begin
            pdata_valid <= 1'b0;
        end
    end

    // Sticky overrun: set on a completion that finds the holder stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (complete && !hold_free) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

`ifdef SIPO_FRAME_PARITY_CHECK_EN
    // Parity error travels with the word it describes
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_err <= 1'b0;
        end else if (complete && hold_free) begin
            parity_err <= word_perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Scoreboard bench for sipo_frame_ctrl (W=8): directed frames push expected
// words; a negedge monitor pops and compares on every output transfer.

module tb_sipo_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sin = 1'b0;
    logic       sin_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic       out_ready = 1'b1;
    logic       ovr_clr = 1'b0;
    logic [7:0] pdata;
    logic       pdata_valid;
    logic       busy;
    logic       overrun;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] d;
        logic       p;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    sipo_frame_ctrl #(.W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .frame_start(frame_start),
        .out_ready  (out_ready),
        .ovr_clr    (ovr_clr),
        .pdata      (pdata),
        .pdata_valid(pdata_valid),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted output word must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && pdata_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h expected none", pdata);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("word", 32'(pdata), 32'(e.d));
                check("parity_err", 32'(parity_err), 32'(e.p));
                if (e.cyc >= 0) check("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        sin         = b;
        sin_valid   = 1'b1;
        frame_start = fs;
        tick();
    endtask

    task automatic idle();
        sin_valid   = 1'b0;
        frame_start = 1'b0;
        sin         = 1'b0;
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i], i == 7);
    endtask

    task automatic push_exp(input logic [7:0] d, input logic p, input bit timed);
        exp_t e;
        e.d   = d;
        e.p   = p;
        e.cyc = timed ? cyc : -1;
        sb.push_back(e);
    endtask

    // Full frame (plus correct parity bit when enabled); optionally expected
    task automatic send_frame(input logic [7:0] d, input bit push, input bit timed);
        send_data(d);
`ifdef SIPO_FRAME_PARITY_CHECK_EN
        send_bit(^d, 1'b0);
`endif
        if (push) push_exp(d, 1'b0, timed);
    endtask

    initial begin
        logic [7:0] resync_bits;

        // Reset state
        tick();
        tick();
        check("rst_pdata", 32'(pdata), 32'h0);
        check("rst_pdata_valid", 32'(pdata_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_parity_err", 32'(parity_err), 32'h0);
        rst = 1'b0;
        tick();

        // Single frame 1,0,1,1,0,0,1,0 -> B2, valid one cycle after last bit
        send_bit(1'b1, 1'b1);
        check("busy_in_frame", 32'(busy), 32'h1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
`ifdef SIPO_FRAME_PARITY_CHECK_EN
        send_bit(1'b0, 1'b0);
`endif
        push_exp(8'hB2, 1'b0, 1'b1);
        idle();
        check("busy_after_frame", 32'(busy), 32'h0);
        tick();
        check("valid_one_cycle", 32'(pdata_valid), 32'h0);
        tick();

        // Back-to-back A5, 3C
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        idle();
        tick();
        tick();
        check("b2b_overrun", 32'(overrun), 32'h0);

        // Stalled consumer: 11 held, 22 dropped, overrun set
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        idle();
        tick();
        check("ovr_set", 32'(overrun), 32'h1);
        check("ovr_held_data", 32'(pdata), 32'h11);
        check("ovr_held_valid", 32'(pdata_valid), 32'h1);
        out_ready = 1'b1;
        tick();
        check("ovr_drained_valid", 32'(pdata_valid), 32'h0);
        check("ovr_sticky", 32'(overrun), 32'h1);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'h0);

        // Resync: 4 partial bits, then a fresh F0 frame
        resync_bits = 8'hF0;
        for (int i = 0; i < 4; i++) send_bit(resync_bits[7 - i] ^ 1'b1, i == 0);
        send_frame(8'hF0, 1'b1, 1'b1);
        idle();
        tick();
        tick();
        check("resync_overrun", 32'(overrun), 32'h0);

        // Reset mid-frame with a held word
        out_ready = 1'b0;
        send_frame(8'h99, 1'b0, 1'b0);
        idle();
        tick();
        check("pre_rst_held", 32'(pdata_valid), 32'h1);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        idle();
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_valid", 32'(pdata_valid), 32'h0);
        check("mid_rst_pdata", 32'(pdata), 32'h0);
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        send_frame(8'h5A, 1'b1, 1'b1);
        idle();
        tick();
        tick();

`ifdef SIPO_FRAME_PARITY_CHECK_EN
        // Parity: 07 has three ones; pbit 1 -> even (ok), pbit 0 -> odd (error)
        send_data(8'h07);
        send_bit(1'b1, 1'b0);
        push_exp(8'h07, 1'b0, 1'b1);
        send_data(8'h07);
        send_bit(1'b0, 1'b0);
        push_exp(8'h07, 1'b1, 1'b1);
        idle();
        tick();
        tick();
`endif

        for (int i = 0; i < 4; i++) tick();
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
